dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache between the single-cycle CPU's load/store path and a slow 256-bit-wide off-chip data memory. It replaces the CPU's direct data-memory connection. Hits complete in the same cycle with no stall. Misses stall the CPU while a finite state machine (FSM) writes back any dirty victim line, refills the line and then completes the access.

---
 rtl/dcache_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store path
// and a 256-bit off-chip memory. Hits complete combinationally; misses stall under FSM control.
module dcache_ctrl #(
   parameter int NUM_LINES  = 32,
   parameter int BLOCK_BITS = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [31:0]           p1_addr_i,
   input  logic [31:0]           p1_data_i,
   input  logic                  p1_MemRead_i,
   input  logic                  p1_MemWrite_i,
   output logic [31:0]           p1_data_o,
   output logic                  p1_stall_o,
   output logic [31:0]           mem_addr_o,
   output logic [BLOCK_BITS-1:0] mem_data_o,
   output logic                  mem_enable_o,
   output logic                  mem_write_o,
   input  logic [BLOCK_BITS-1:0] mem_data_i,
   input  logic                  mem_ack_i
);

   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
   localparam int WORD_W = OFF_W - 2;
   localparam int TAG_W  = 32 - IDX_W - OFF_W;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_MISS       = 3'd1,
      S_WRITEBACK  = 3'd2,
      S_READMISS   = 3'd3,
      S_READMISSOK = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic [NUM_LINES-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [BLOCK_BITS-1:0]  data_q [NUM_LINES];

   logic                   mem_enable_q, mem_enable_d;
   logic                   mem_write_q, mem_write_d;
   logic [31:0]            mem_addr_q, mem_addr_d;
   logic [BLOCK_BITS-1:0]  mem_data_q, mem_data_d;

   logic [TAG_W-1:0]       req_tag_s;
   logic [IDX_W-1:0]       idx_s;
   logic [WORD_W-1:0]      word_s;
   logic                   req_s;
   logic                   hit_s;
   logic                   idle_hit_s;
   logic [BLOCK_BITS-1:0]  cur_line_s;
   logic [BLOCK_BITS-1:0]  merged_line_s;
   logic                   line_we_s;
   logic                   tag_we_s;
   logic [BLOCK_BITS-1:0]  line_wdata_s;
   logic                   unused_addr_s;

   assign req_tag_s     = p1_addr_i[31:32-TAG_W];
   assign idx_s         = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
   assign word_s        = p1_addr_i[OFF_W-1:2];
   assign unused_addr_s = ^p1_addr_i[1:0];
   assign req_s         = p1_MemRead_i | p1_MemWrite_i;
   assign cur_line_s    = data_q[idx_s];
   assign hit_s         = valid_q[idx_s] & (tag_q[idx_s] == req_tag_s);
   assign idle_hit_s    = (state_q == S_IDLE) & hit_s;

   // CPU-facing outputs: stall on any request that cannot hit right now
   always_comb begin
      p1_stall_o = req_s & ~idle_hit_s;
      if (idle_hit_s & p1_MemRead_i & ~p1_MemWrite_i) begin
         p1_data_o = cur_line_s[{word_s, 5'b00000} +: 32];
      end else begin
         p1_data_o = 32'h0000_0000;
      end
   end

   // Store data merged into the indexed line for a write hit
   always_comb begin
      merged_line_s = cur_line_s;
      merged_line_s[{word_s, 5'b00000} +: 32] = p1_data_i;
   end

   // Next-state, line update and Moore memory-request decode
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      line_we_s    = 1'b0;
      tag_we_s     = 1'b0;
      line_wdata_s = merged_line_s;
      case (state_q)
         S_IDLE: begin
            if (req_s & ~hit_s) begin
               state_d = S_MISS;
            end else if (p1_MemWrite_i) begin
               line_we_s      = 1'b1;
               dirty_d[idx_s] = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MISS: begin
            if (valid_q[idx_s] & dirty_q[idx_s]) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_READMISS;
            end
         end
         S_WRITEBACK: begin
            if (mem_ack_i) begin
               state_d = S_READMISS;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_READMISS: begin
            if (mem_ack_i) begin
               state_d        = S_READMISSOK;
               line_we_s      = 1'b1;
               tag_we_s       = 1'b1;
               line_wdata_s   = mem_data_i;
               valid_d[idx_s] = 1'b1;
               dirty_d[idx_s] = 1'b0;
            end else begin
               state_d = S_READMISS;
            end
         end
         S_READMISSOK: state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase

      // Registered alongside the state so the outputs follow the state register exactly
      mem_enable_d = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = 32'h0000_0000;
      mem_data_d   = '0;
      case (state_d)
         S_WRITEBACK: begin
            mem_enable_d = 1'b1;
            mem_write_d  = 1'b1;
            mem_addr_d   = {tag_q[idx_s], idx_s, {OFF_W{1'b0}}};
            mem_data_d   = cur_line_s;
         end
         S_READMISS: begin
            mem_enable_d = 1'b1;
            mem_addr_d   = {req_tag_s, idx_s, {OFF_W{1'b0}}};
         end
         default: begin
            mem_enable_d = 1'b0;
         end
      endcase
   end

   // Control state, line status bits and memory request registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

   // Tag and data arrays carry no reset; valid bits qualify them
   always_ff @(posedge clk_i) begin
      if (line_we_s) data_q[idx_s] <= line_wdata_s;
      if (tag_we_s)  tag_q[idx_s]  <= req_tag_s;
   end

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

endmodule
